// File: rtl/output_stream_writer.sv
// Stream-to-memory sink: buffers a fixed-length valid/ready stream in a small FIFO
// and writes each word to base_addr + k*stride. Optional macro OUTPUT_STREAM_WRITER_PERF_EN adds stall_cnt.
module output_stream_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_v,
  output logic                  din_r,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           stride,
  input  logic [15:0]           length,
  input  logic                  soft_clear,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done
`ifdef OUTPUT_STREAM_WRITER_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           stride_q, len_q, acc_cnt, wr_cnt;
  logic                  push, pop, start_run, last_write;

  // The extra wrap bit tells full (same index, different lap) from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign din_r      = (state == RUN) && !fifo_full && (acc_cnt < len_q);
  assign push       = din_v && din_r;
  assign mem_req    = (state == RUN) && !fifo_empty;
  assign mem_we     = mem_req;
  assign pop        = mem_req && mem_gnt;
  assign mem_addr   = addr_q;
  assign mem_wdata  = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign start_run  = (state == IDLE) && start && (length != 16'd0);
  assign last_write = pop && ((wr_cnt + 16'd1) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (length == 16'd0) ? DONE : RUN;
      RUN:  if (last_write) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (soft_clear) state_next = IDLE;
  end

  // Storage is reset so mem_wdata reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push && !soft_clear) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
    end else if (soft_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (start_run) begin
        addr_q   <= base_addr;
        stride_q <= stride;
        len_q    <= length;
        acc_cnt  <= '0;
        wr_cnt   <= '0;
      end
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        acc_cnt <= acc_cnt + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        addr_q <= addr_q + ADDR_WIDTH'(stride_q);
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

`ifdef OUTPUT_STREAM_WRITER_PERF_EN
  // Counts denied write requests for the current run, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_run && !soft_clear) begin
      stall_cnt <= '0;
    end else if (mem_req && !mem_gnt && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_stream_writer.sv
// Directed self-checking bench for output_stream_writer: a vector table for the basic
// transfer plus hand-written backpressure, length, wrap, abort, reset and perf sequences.
module tb_output_stream_writer;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        din_v;
  logic        din_r;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] stride;
  logic [15:0] length;
  logic        soft_clear;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
`ifdef OUTPUT_STREAM_WRITER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  output_stream_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_v(din_v), .din_r(din_r),
    .start(start), .base_addr(base_addr), .stride(stride), .length(length),
    .soft_clear(soft_clear), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done)
`ifdef OUTPUT_STREAM_WRITER_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        din_v;
    logic [31:0] din;
    logic        gnt;
    logic        exp_din_r;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic s, input logic dv, input logic [31:0] d,
                               input logic g, input logic sc);
    @(negedge clk);
    start = s; din_v = dv; din = d; mem_gnt = g; soft_clear = sc;
    #1;
  endtask

  task automatic runTransfer(input logic [31:0] b, input logic [15:0] s, input logic [15:0] l,
                             input int offered, input logic [31:0] seed, input string tag);
    int sent = 0;
    int k = 0;
    int dones = 0;
    base_addr = b; stride = s; length = l;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int c = 0; c < 40 && dones == 0; c++) begin
      applyStimulus(1'b0, sent < offered, 32'(seed + 32'(sent)), 1'b1, 1'b0);
      if (done) dones++;
      if (mem_req) begin
        checkOutput({tag, " addr"}, 64'(mem_addr), 64'(32'(b + 32'(k) * 32'(s))));
        checkOutput({tag, " wdata"}, 64'(mem_wdata), 64'(32'(seed + 32'(k))));
        k++;
      end
      if (din_r && din_v) sent++;
    end
    checkOutput({tag, " write count"}, 64'(k), 64'(l));
    checkOutput({tag, " done seen"}, 64'(dones), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput({tag, " done cleared"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pushed;
    int k;
    int got_done;

    rst_n = 1'b0; start = 1'b0; din = '0; din_v = 1'b0; mem_gnt = 1'b0;
    soft_clear = 1'b0; base_addr = '0; stride = '0; length = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0,         1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'hAAAA_0002, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hAAAA_0001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'hAAAA_0003, 1'b1, 1'b1, 1'b1, 32'h1004, 32'hAAAA_0002, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'hAAAA_0004, 1'b1, 1'b0, 1'b1, 32'h1008, 32'hAAAA_0003, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h100C, 32'h0,         1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h100C, 32'h0,         1'b0, 1'b0};

    #1;
    checkOutput("reset din_r", 64'(din_r), 64'd0);
    checkOutput("reset mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(mem_wdata), 64'd0);
`ifdef OUTPUT_STREAM_WRITER_PERF_EN
    checkOutput("reset stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic transfer");
    base_addr = 32'h1000; stride = 16'd4; length = 16'd3;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].start, vecs[i].din_v, vecs[i].din, vecs[i].gnt, 1'b0);
      checkOutput($sformatf("vec%0d din_r", i), 64'(din_r), 64'(vecs[i].exp_din_r));
      checkOutput($sformatf("vec%0d mem_req", i), 64'(mem_req), 64'(vecs[i].exp_req));
      checkOutput($sformatf("vec%0d mem_we", i), 64'(mem_we), 64'(vecs[i].exp_req));
      checkOutput($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].exp_addr));
      if (vecs[i].exp_req)
        checkOutput($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_wdata));
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].exp_done));
    end

    $display("[TB] backpressure");
    base_addr = 32'h2000; stride = 16'd4; length = 16'd6;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    pushed = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(32'hB000_0000 + 32'(pushed)), 1'b0, 1'b0);
      checkOutput($sformatf("bp din_r c%0d", i), 64'(din_r), 64'(i < 4));
      if (i >= 1) begin
        checkOutput($sformatf("bp mem_req c%0d", i), 64'(mem_req), 64'd1);
        checkOutput($sformatf("bp mem_addr c%0d", i), 64'(mem_addr), 64'h2000);
        checkOutput($sformatf("bp mem_wdata c%0d", i), 64'(mem_wdata), 64'hB000_0000);
      end
      if (din_r) pushed++;
    end
    k = 0; got_done = 0;
    for (int j = 0; j < 30 && got_done == 0; j++) begin
      applyStimulus(1'b0, pushed < 6, 32'(32'hB000_0000 + 32'(pushed)), 1'b1, 1'b0);
      if (j == 0) checkOutput("bp full no bypass din_r", 64'(din_r), 64'd0);
      if (done) got_done = 1;
      if (mem_req) begin
        checkOutput($sformatf("bp drain addr %0d", k), 64'(mem_addr), 64'(32'(32'h2000 + 32'(k) * 4)));
        checkOutput($sformatf("bp drain wdata %0d", k), 64'(mem_wdata), 64'(32'(32'hB000_0000 + 32'(k))));
        k++;
      end
      if (din_r && din_v) pushed++;
    end
    checkOutput("bp write count", 64'(k), 64'd6);
    checkOutput("bp done seen", 64'(got_done), 64'd1);

    $display("[TB] length boundaries");
    base_addr = 32'h2800; stride = 16'd4; length = 16'd0;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h1234, 1'b1, 1'b0);
    checkOutput("len0 done", 64'(done), 64'd1);
    checkOutput("len0 mem_req", 64'(mem_req), 64'd0);
    checkOutput("len0 din_r", 64'(din_r), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("len0 done cleared", 64'(done), 64'd0);
    checkOutput("len0 busy", 64'(busy), 64'd0);

    length = 16'd2; base_addr = 32'h3000;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    pushed = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(32'hC000_0000 + 32'(pushed)), 1'b0, 1'b0);
      checkOutput($sformatf("len2 din_r c%0d", i), 64'(din_r), 64'(i < 2));
      if (din_r) pushed++;
    end
    k = 0; got_done = 0;
    for (int j = 0; j < 10 && got_done == 0; j++) begin
      applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      checkOutput($sformatf("len2 drain din_r %0d", j), 64'(din_r), 64'd0);
      if (done) got_done = 1;
      if (mem_req) begin
        checkOutput($sformatf("len2 wdata %0d", k), 64'(mem_wdata), 64'(32'(32'hC000_0000 + 32'(k))));
        k++;
      end
    end
    checkOutput("len2 write count", 64'(k), 64'd2);
    checkOutput("len2 done seen", 64'(got_done), 64'd1);

    $display("[TB] address wrap and zero stride");
    runTransfer(32'hFFFF_FFFC, 16'd8, 16'd2, 2, 32'hD000_0000, "wrap");
    runTransfer(32'h0000_5000, 16'd0, 16'd3, 4, 32'hD100_0000, "stride0");

    $display("[TB] soft_clear abort");
    base_addr = 32'h3000; stride = 16'd4; length = 16'd4;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hE000_0000, 1'b0, 1'b0);
    checkOutput("abort push0 din_r", 64'(din_r), 64'd1);
    applyStimulus(1'b0, 1'b1, 32'hE000_0001, 1'b0, 1'b0);
    checkOutput("abort push1 din_r", 64'(din_r), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("abort pre-clear mem_req", 64'(mem_req), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort mem_req", 64'(mem_req), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort din_r", 64'(din_r), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("abort no late done", 64'(done), 64'd0);
    runTransfer(32'h0000_4000, 16'd4, 16'd2, 2, 32'hE100_0000, "after abort");

    $display("[TB] async reset during run");
    base_addr = 32'h6000; stride = 16'd4; length = 16'd4;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hF000_0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("rst pre mem_req", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst din_r", 64'(din_r), 64'd0);
    checkOutput("rst done", 64'(done), 64'd0);
    checkOutput("rst mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst mem_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef OUTPUT_STREAM_WRITER_PERF_EN
    $display("[TB] stall counter");
    base_addr = 32'h7000; stride = 16'd4; length = 16'd1;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h5555_0000, 1'b0, 1'b0);
    checkOutput("perf cleared on start", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput($sformatf("perf mem_req c%0d", i), 64'(mem_req), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("perf stall_cnt", 64'(stall_cnt), 64'd5);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("perf done", 64'(done), 64'd1);
    checkOutput("perf stall_cnt hold", 64'(stall_cnt), 64'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
